croma_config_fsm: RTL and testbench
===================================

// Module: croma_config_fsm
// PURPOSE
//  Sequences colour/tone configuration for the VGA output path. Debounces the Up, Down, TC and Lp
//  buttons and edits shadow registers for letter colour, background colour and tone. Commits the
//  shadow values to the live ColorL/ColorP/ton outputs only at the Vsinc falling edge, so no frame
//  tears. Runs on the pixel clock; drives controldesalida in place of the unsynchronised chroma path.
// PARAMETERS
//  DB_CYCLES  250000  clocks a synchronised button must hold steady before it is accepted (>=2)
//  TON_STEP   16      tone increment/decrement per press
//  TON_RST    8'h80   tone value after reset
// PORTS
//  Clk        in   1  pixel clock
//  reset      in   1  asynchronous, active-high reset
//  Up         in   1  raw button: increment selected field
//  Down       in   1  raw button: decrement selected field
//  TC         in   1  raw button: toggle edited field (colour <-> tone)
//  Lp         in   1  raw button: toggle target (letter <-> background)
//  Vsinc      in   1  vertical sync from generadorVsync, active low, Clk-synchronous
//  ColorL     out  3  live letter colour {R,G,B} enables
//  ColorP     out  3  live background colour {R,G,B} enables
//  ton        out  8  live tone/intensity
//  sel_letra  out  1  1 = edits target letter colour, 0 = background colour
//  sel_tono   out  1  1 = Up/Down edit ton, 0 = edit colour of the selected target
//  pendiente  out  1  1 = shadow holds uncommitted edits
// BEHAVIOUR
//  Reset (async, immediate): ColorL=3'b111, ColorP=3'b000, ton=TON_RST. Shadows take the same values.
//   sel_letra=1, sel_tono=0, pendiente=0, FSM=IDLE, debouncers cleared (accepted level 0).
//  Button path (per button): 2-FF synchroniser -> counter reloads on any change -> accepted level
//   updates after DB_CYCLES stable clocks -> 1-cycle press pulse on accepted 0->1.
//   Latency from a clean input edge to the press pulse is DB_CYCLES+2 clocks. Releases make no pulse.
//  Press handling, same cycle, priority Lp > TC > Up/Down; lower-priority pulses that cycle are dropped:
//   Lp: invert sel_letra.  TC: invert sel_tono.
//   Up and Down together: both ignored, no edit.
//   Up, sel_tono=0: selected shadow colour +1 mod 8 (3'b111 -> 3'b000 wraps).
//   Down, sel_tono=0: selected shadow colour -1 mod 8 (3'b000 -> 3'b111 wraps).
//   Up, sel_tono=1: shadow ton = min(ton+TON_STEP, 255); 9-bit sum, saturates.
//   Down, sel_tono=1: shadow ton = max(ton-TON_STEP, 0); saturates, no wrap.
//   An accepted Up/Down sets pendiente=1, including a saturated no-change press.
//  FSM states:
//   IDLE: pendiente=0. An Up/Down edit goes to PEND.
//   PEND: pendiente=1; further edits accumulate in the shadows. Vsinc falling edge (registered
//    Vsinc=1, current Vsinc=0) goes to COMMIT.
//   COMMIT: one cycle. Live outputs <= shadows, visible the next clock. Returns to IDLE, or to PEND
//    if an edit is accepted in this cycle.
//  The edge-detect register powers up to 1. A Vsinc held low at reset release does not commit.
//  An edit landing in the same cycle as the commit copy is not in that commit. It goes out at the
//   next frame edge.
//  Live outputs change only in COMMIT or on reset. sel_letra and sel_tono change immediately.
//  Reset mid-PEND discards shadow edits. No commit follows until a new edit is made.
// TESTING  (DB_CYCLES=4, TON_STEP=16)
//  1. Reset, then Up held 10 clks -> one press pulse 6 clks after the edge. Shadow ColorL=000
//     (wrap), pendiente=1, ColorL stays 111 until the Vsinc fall, then reads 000 one clk later.
//  2. Up glitches of 3 clks, repeated -> no press pulse, no state change.
//  3. TC, then Down x9 from ton=80 -> shadow ton saturates at 00. After the Vsinc fall ton=00;
//     Up x20 -> ton=FF.
//  4. Lp and Up pressed in the same cycle -> sel_letra=0, ColorP unchanged, pendiente=0.
//  5. Up and Down accepted together -> no edit; an edit in the COMMIT cycle -> FSM goes to PEND
//     and commits at the next frame.
//  6. Assert reset while in PEND with shadow ColorP=101 -> outputs return to reset values; the
//     next Vsinc fall leaves ColorP=000.

Source files
------------

// File: rtl/croma_config_fsm.sv
// rtl/croma_config_fsm.sv - debounced colour/tone editor that commits shadows to live outputs on Vsinc fall
module croma_config_fsm #(
  parameter int         DB_CYCLES = 250000,
  parameter int         TON_STEP  = 16,
  parameter logic [7:0] TON_RST   = 8'h80
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       Up,
  input  logic       Down,
  input  logic       TC,
  input  logic       Lp,
  input  logic       Vsinc,
  output logic [2:0] ColorL,
  output logic [2:0] ColorP,
  output logic [7:0] ton,
  output logic       sel_letra,
  output logic       sel_tono,
  output logic       pendiente
);

  localparam int CW = $clog2(DB_CYCLES);

  typedef enum logic [1:0] {IDLE, PEND, COMMIT} state_t;

  state_t        r_state;
  logic [3:0]    r_sync1, r_sync2, r_acc, r_press;
  logic [CW-1:0] r_cnt [4];
  logic          r_vs_d;
  logic [2:0]    r_sh_l, r_sh_p;
  logic [7:0]    r_sh_ton;

  logic [3:0]    w_raw;
  logic          w_lp, w_tc, w_up, w_dn, w_edit, w_vs_fall;
  logic [8:0]    w_ton_sum, w_ton_diff;
  logic [7:0]    w_ton_new;
  logic [2:0]    w_col_sel, w_col_new;

  assign w_raw = {Lp, TC, Down, Up};

  // Counter only runs while the synchronised level disagrees with the accepted one.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_acc   <= '0;
      r_press <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 4; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync2[i] == r_acc[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CW'(DB_CYCLES - 1)) begin
          r_cnt[i]   <= '0;
          r_acc[i]   <= r_sync2[i];
          r_press[i] <= r_sync2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign w_lp      = r_press[3];
  assign w_tc      = r_press[2] & ~r_press[3];
  assign w_up      = r_press[0] & ~r_press[1] & ~r_press[2] & ~r_press[3];
  assign w_dn      = r_press[1] & ~r_press[0] & ~r_press[2] & ~r_press[3];
  assign w_edit    = w_up | w_dn;
  assign w_vs_fall = r_vs_d & ~Vsinc;

  assign w_ton_sum  = {1'b0, r_sh_ton} + 9'(TON_STEP);
  assign w_ton_diff = {1'b0, r_sh_ton} - 9'(TON_STEP);
  assign w_ton_new  = w_up ? (w_ton_sum[8] ? 8'hFF : w_ton_sum[7:0])
                           : (w_ton_diff[8] ? 8'h00 : w_ton_diff[7:0]);
  assign w_col_sel  = sel_letra ? r_sh_l : r_sh_p;
  assign w_col_new  = w_up ? w_col_sel + 3'd1 : w_col_sel - 3'd1;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_vs_d    <= 1'b1;
      ColorL    <= 3'b111;
      ColorP    <= 3'b000;
      ton       <= TON_RST;
      r_sh_l    <= 3'b111;
      r_sh_p    <= 3'b000;
      r_sh_ton  <= TON_RST;
      sel_letra <= 1'b1;
      sel_tono  <= 1'b0;
      pendiente <= 1'b0;
    end else begin
      r_vs_d <= Vsinc;
      if (w_lp) sel_letra <= ~sel_letra;
      if (w_tc) sel_tono  <= ~sel_tono;
      if (w_edit) begin
        if (sel_tono)       r_sh_ton <= w_ton_new;
        else if (sel_letra) r_sh_l   <= w_col_new;
        else                r_sh_p   <= w_col_new;
      end
      case (r_state)
        IDLE: begin
          if (w_edit) begin
            r_state   <= PEND;
            pendiente <= 1'b1;
          end
        end
        PEND: begin
          if (w_vs_fall) r_state <= COMMIT;
        end
        COMMIT: begin
          // Copies pre-edit shadows; an edit landing now waits for the next frame.
          ColorL    <= r_sh_l;
          ColorP    <= r_sh_p;
          ton       <= r_sh_ton;
          r_state   <= w_edit ? PEND : IDLE;
          pendiente <= w_edit;
        end
        default: begin
          r_state   <= IDLE;
          pendiente <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_croma_config_fsm.sv
// tb/tb_croma_config_fsm.sv - randomized and directed bench against a press-level reference model
module tb_croma_config_fsm;

  logic       Clk = 1'b0;
  logic       reset, Up, Down, TC, Lp, Vsinc;
  logic [2:0] ColorL, ColorP;
  logic [7:0] ton;
  logic       sel_letra, sel_tono, pendiente;

  int checks   = 0;
  int failures = 0;

  // Reference model state: live and shadow values, selectors, pending flag.
  int m_l, m_p, m_ton, s_l, s_p, s_ton, m_sel_l, m_sel_t, m_pend;

  croma_config_fsm #(.DB_CYCLES(4), .TON_STEP(16), .TON_RST(8'h80)) dut (
    .Clk(Clk), .reset(reset), .Up(Up), .Down(Down), .TC(TC), .Lp(Lp), .Vsinc(Vsinc),
    .ColorL(ColorL), .ColorP(ColorP), .ton(ton),
    .sel_letra(sel_letra), .sel_tono(sel_tono), .pendiente(pendiente)
  );

  always #5 Clk = ~Clk;

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ColorL"},    int'(ColorL),    m_l);
    chk({tag, ".ColorP"},    int'(ColorP),    m_p);
    chk({tag, ".ton"},       int'(ton),       m_ton);
    chk({tag, ".sel_letra"}, int'(sel_letra), m_sel_l);
    chk({tag, ".sel_tono"},  int'(sel_tono),  m_sel_t);
    chk({tag, ".pendiente"}, int'(pendiente), m_pend);
  endtask

  task automatic m_reset();
    m_l = 7; m_p = 0; m_ton = 128;
    s_l = 7; s_p = 0; s_ton = 128;
    m_sel_l = 1; m_sel_t = 0; m_pend = 0;
  endtask

  task automatic m_press(input int u, input int d, input int t, input int l);
    int delta;
    if (l != 0) m_sel_l = 1 - m_sel_l;
    else if (t != 0) m_sel_t = 1 - m_sel_t;
    else if ((u != 0) != (d != 0)) begin
      delta = (u != 0) ? 1 : -1;
      if (m_sel_t != 0) begin
        s_ton = s_ton + 16 * delta;
        if (s_ton > 255) s_ton = 255;
        if (s_ton < 0) s_ton = 0;
      end else if (m_sel_l != 0) s_l = (s_l + delta + 8) % 8;
      else s_p = (s_p + delta + 8) % 8;
      m_pend = 1;
    end
  endtask

  task automatic m_commit();
    m_l = s_l; m_p = s_p; m_ton = s_ton; m_pend = 0;
  endtask

  task automatic press(input int u, input int d, input int t, input int l, input string tag);
    Up = u[0]; Down = d[0]; TC = t[0]; Lp = l[0];
    step(10);
    Up = 1'b0; Down = 1'b0; TC = 1'b0; Lp = 1'b0;
    step(10);
    m_press(u, d, t, l);
    check_all(tag);
  endtask

  task automatic frame(input string tag);
    Vsinc = 1'b0;
    step(1);
    chk({tag, ".hold"}, int'(ColorL), m_l);
    step(1);
    m_commit();
    check_all(tag);
    Vsinc = 1'b1;
    step(2);
  endtask

  initial begin
    reset = 1'b1; Up = 1'b0; Down = 1'b0; TC = 1'b0; Lp = 1'b0; Vsinc = 1'b1;
    m_reset();
    step(3);
    check_all("reset");
    reset = 1'b0;
    step(2);

    // Up edge: pulse lands after 6 clocks, edit visible after the 7th.
    Up = 1'b1;
    step(6);
    chk("lat.before", int'(pendiente), 0);
    step(1);
    chk("lat.after", int'(pendiente), 1);
    chk("lat.live", int'(ColorL), 7);
    step(3);
    Up = 1'b0;
    step(10);
    m_press(1, 0, 0, 0);
    check_all("up_wrap");
    frame("commit1");

    for (int k = 0; k < 4; k++) begin
      Up = 1'b1; step(3);
      Up = 1'b0; step(2);
    end
    step(10);
    check_all("glitch");

    press(0, 0, 1, 0, "tc");
    for (int k = 0; k < 9; k++) press(0, 1, 0, 0, "ton_dn");
    frame("ton_zero");
    for (int k = 0; k < 20; k++) press(1, 0, 0, 0, "ton_up");
    frame("ton_ff");
    press(0, 0, 1, 0, "tc_back");

    press(1, 0, 0, 1, "lp_up");
    press(1, 1, 0, 0, "up_dn");
    frame("no_edit_frame");

    press(0, 1, 0, 0, "pre_commit_edit");
    Down = 1'b1;
    step(5);
    Vsinc = 1'b0;
    step(2);
    m_commit();
    m_press(0, 1, 0, 0);
    check_all("edit_in_commit");
    Down = 1'b0;
    Vsinc = 1'b1;
    step(12);
    frame("next_frame");

    for (int k = 0; k < 40; k++) begin
      int b;
      b = int'($urandom_range(0, 15));
      press(b & 1, (b >> 1) & 1, (b >> 2) & 1, (b >> 3) & 1, "rand");
      if ($urandom_range(0, 3) == 0) frame("rand_frame");
    end

    reset = 1'b1; step(1); reset = 1'b0; step(2);
    m_reset();
    press(0, 0, 0, 1, "rst6.lp");
    for (int k = 0; k < 3; k++) press(0, 1, 0, 0, "rst6.dn");
    chk("rst6.shadow_pending", int'(pendiente), 1);
    reset = 1'b1;
    #1;
    m_reset();
    check_all("rst6.async");
    step(1);
    reset = 1'b0;
    step(2);
    frame("rst6.frame");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
